fetch_pc_sequencer: RTL and testbench

Registered program-counter controller for the fetch stage. It owns the PC register and chooses the next PC each cycle from the reset vector, the interrupt vector, the return address popped from the stack, the branch target, or PC+1. It also sequences the two-cycle interrupt entry (save PC, then vector), marks the immediate word that follows an LDM, and issues flush requests for the IF/ID buffer. It sits between the hazard/branch logic and the instruction memory address port.

---
 rtl/fetch_pc_sequencer.sv | 98 +++++++++
 tb/tb_fetch_pc_sequencer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_sequencer.sv
// Fetch-stage program-counter controller: owns the PC register, selects the
// next PC, sequences the two-cycle interrupt entry, and tracks LDM immediates.
module fetch_pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0020,
  parameter logic [31:0] INT_VECTOR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        ret_valid,
  input  logic [31:0] ret_pc,
  input  logic        int_req,
  input  logic        is_ldm,
  output logic [31:0] pc,
  output logic [31:0] pc_plus1,
  output logic        imm_slot,
  output logic        flush,
  output logic        push_valid,
  output logic [31:0] push_pc,
  output logic        int_ack
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    INT_SAVE = 2'd1,
    INT_JUMP = 2'd2
  } state_t;

  state_t state;
  logic   int_pending;
  logic   int_go;
  logic   redirect;

  // Next-PC decisions and the single-cycle pulses decoded from the current state.
  always_comb begin
    pc_plus1   = pc + 32'd1;
    // An interrupt may only be taken between instructions, never between an
    // LDM and its immediate word.
    int_go     = (int_pending | int_req) & ~imm_slot & ~is_ldm;
    redirect   = (state == RUN) & ~stall & ~int_go & (ret_valid | branch_taken);
    flush      = ~reset & (redirect | (state == INT_SAVE) | (state == INT_JUMP));
    push_valid = ~reset & (state == INT_SAVE);
    int_ack    = ~reset & (state == INT_JUMP);
  end

  // PC register, interrupt-entry FSM, pending flag and immediate-slot tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      pc          <= RESET_VECTOR;
      imm_slot    <= 1'b0;
      int_pending <= 1'b0;
      push_pc     <= '0;
    end else begin
      if (state == INT_JUMP) begin
        int_pending <= 1'b0;
      end else if (int_req) begin
        int_pending <= 1'b1;
      end

      case (state)
        RUN: begin
          if (!stall) begin
            if (int_go) begin
              // pc is held through INT_SAVE, so capturing it here gives the
              // first unexecuted instruction as the return address.
              state   <= INT_SAVE;
              push_pc <= pc;
            end else if (ret_valid) begin
              pc       <= ret_pc;
              imm_slot <= 1'b0;
            end else if (branch_taken) begin
              pc       <= branch_target;
              imm_slot <= 1'b0;
            end else begin
              pc       <= pc_plus1;
              imm_slot <= is_ldm & ~imm_slot;
            end
          end
        end
        INT_SAVE: begin
          state <= INT_JUMP;
        end
        INT_JUMP: begin
          pc       <= INT_VECTOR;
          imm_slot <= 1'b0;
          state    <= RUN;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Directed bench for fetch_pc_sequencer: reset, free run, redirect priority,
// stall, LDM interrupt deferral, interrupt entry/return, reset abort, wrap.
module tb_fetch_pc_sequencer;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        ret_valid;
  logic [31:0] ret_pc;
  logic        int_req;
  logic        is_ldm;
  logic [31:0] pc;
  logic [31:0] pc_plus1;
  logic        imm_slot;
  logic        flush;
  logic        push_valid;
  logic [31:0] push_pc;
  logic        int_ack;

  int unsigned checks;
  int unsigned errors;

  fetch_pc_sequencer #(
    .RESET_VECTOR(32'h0000_0020),
    .INT_VECTOR  (32'h0000_0000)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .ret_valid    (ret_valid),
    .ret_pc       (ret_pc),
    .int_req      (int_req),
    .is_ldm       (is_ldm),
    .pc           (pc),
    .pc_plus1     (pc_plus1),
    .imm_slot     (imm_slot),
    .flush        (flush),
    .push_valid   (push_valid),
    .push_pc      (push_pc),
    .int_ack      (int_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reset         = 1'b0;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = '0;
    ret_valid     = 1'b0;
    ret_pc        = '0;
    int_req       = 1'b0;
    is_ldm        = 1'b0;
  endtask

  // Moves the PC to a chosen address with a one-cycle branch.
  task automatic goto_pc(input logic [31:0] target);
    branch_taken  = 1'b1;
    branch_target = target;
    tick();
    branch_taken  = 1'b0;
    branch_target = '0;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (pc !== 32'h20) begin errors++; $display("FAIL reset_pc got %h want %h", pc, 32'h20); end
    checks++;
    if (pc_plus1 !== 32'h21) begin errors++; $display("FAIL reset_pc_plus1 got %h want %h", pc_plus1, 32'h21); end
    checks++;
    if ({imm_slot, flush, push_valid, int_ack} !== 4'b0000)
      begin errors++; $display("FAIL reset_flags got %b want 0000", {imm_slot, flush, push_valid, int_ack}); end
    checks++;
    if (push_pc !== 32'h0) begin errors++; $display("FAIL reset_push_pc got %h want 0", push_pc); end
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if (pc !== 32'h20 + 32'(i)) begin errors++; $display("FAIL free_run_%0d got %h want %h", i, pc, 32'h20 + 32'(i)); end
      checks++;
      if ({flush, push_valid, int_ack} !== 3'b000)
        begin errors++; $display("FAIL free_run_pulses_%0d got %b want 000", i, {flush, push_valid, int_ack}); end
    end
  endtask

  task automatic test_branch_vs_return();
    tick();
    tick();
    checks++;
    if (pc !== 32'h25) begin errors++; $display("FAIL br_ret_start got %h want %h", pc, 32'h25); end
    branch_taken  = 1'b1;
    branch_target = 32'h40;
    ret_valid     = 1'b1;
    ret_pc        = 32'h80;
    #1;
    checks++;
    if (flush !== 1'b1) begin errors++; $display("FAIL br_ret_flush got %b want 1", flush); end
    tick();
    idle_inputs();
    #1;
    checks++;
    if (pc !== 32'h80) begin errors++; $display("FAIL br_ret_pc got %h want %h", pc, 32'h80); end
    checks++;
    if (flush !== 1'b0) begin errors++; $display("FAIL br_ret_flush_drop got %b want 0", flush); end
  endtask

  task automatic test_stall();
    goto_pc(32'h30);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (pc !== 32'h30) begin errors++; $display("FAIL stall_hold_%0d got %h want %h", i, pc, 32'h30); end
      checks++;
      if (flush !== 1'b0) begin errors++; $display("FAIL stall_flush_%0d got %b want 0", i, flush); end
    end
    stall = 1'b0;
    tick();
    checks++;
    if (pc !== 32'h31) begin errors++; $display("FAIL stall_release got %h want %h", pc, 32'h31); end
  endtask

  task automatic test_ldm_pair();
    goto_pc(32'h28);
    is_ldm = 1'b1;
    tick();
    is_ldm = 1'b0;
    #1;
    checks++;
    if (pc !== 32'h29) begin errors++; $display("FAIL ldm_pc got %h want %h", pc, 32'h29); end
    checks++;
    if (imm_slot !== 1'b1) begin errors++; $display("FAIL ldm_imm_slot got %b want 1", imm_slot); end
    // A request on the immediate word must be deferred until after it.
    is_ldm  = 1'b1;
    int_req = 1'b1;
    #1;
    checks++;
    if (flush !== 1'b0) begin errors++; $display("FAIL ldm_defer_flush got %b want 0", flush); end
    tick();
    int_req = 1'b0;
    is_ldm  = 1'b0;
    #1;
    checks++;
    if (pc !== 32'h2A || imm_slot !== 1'b0 || push_valid !== 1'b0)
      begin errors++; $display("FAIL ldm_after_imm got pc=%h imm=%b push=%b want pc=2a imm=0 push=0", pc, imm_slot, push_valid); end
    tick();
    checks++;
    if (push_valid !== 1'b1 || push_pc !== 32'h2A || flush !== 1'b1)
      begin errors++; $display("FAIL ldm_save got push=%b push_pc=%h flush=%b want 1 2a 1", push_valid, push_pc, flush); end
    tick();
    checks++;
    if (int_ack !== 1'b1 || push_valid !== 1'b0 || flush !== 1'b1)
      begin errors++; $display("FAIL ldm_jump got ack=%b push=%b flush=%b want 1 0 1", int_ack, push_valid, flush); end
    tick();
    checks++;
    if (pc !== 32'h0 || int_ack !== 1'b0 || flush !== 1'b0)
      begin errors++; $display("FAIL ldm_vector got pc=%h ack=%b flush=%b want 0 0 0", pc, int_ack, flush); end
  endtask

  task automatic test_interrupt();
    goto_pc(32'h50);
    int_req = 1'b1;
    tick();
    int_req = 1'b0;
    // INT_SAVE must ignore stall and drop a late branch.
    stall         = 1'b1;
    branch_taken  = 1'b1;
    branch_target = 32'h99;
    #1;
    checks++;
    if (push_valid !== 1'b1 || push_pc !== 32'h50 || pc !== 32'h50)
      begin errors++; $display("FAIL int_save got push=%b push_pc=%h pc=%h want 1 50 50", push_valid, push_pc, pc); end
    tick();
    stall = 1'b0;
    #1;
    checks++;
    if (int_ack !== 1'b1 || push_valid !== 1'b0)
      begin errors++; $display("FAIL int_jump got ack=%b push=%b want 1 0", int_ack, push_valid); end
    tick();
    branch_taken = 1'b0;
    #1;
    checks++;
    if (pc !== 32'h0 || int_ack !== 1'b0)
      begin errors++; $display("FAIL int_vector got pc=%h ack=%b want 0 0", pc, int_ack); end
    tick();
    tick();
    checks++;
    if (pc !== 32'h2) begin errors++; $display("FAIL int_handler_run got %h want 2", pc); end
    ret_valid = 1'b1;
    ret_pc    = 32'h50;
    tick();
    ret_valid = 1'b0;
    #1;
    checks++;
    if (pc !== 32'h50) begin errors++; $display("FAIL int_return got %h want %h", pc, 32'h50); end
  endtask

  task automatic test_reset_int_jump();
    goto_pc(32'h60);
    int_req = 1'b1;
    tick();
    int_req = 1'b0;
    tick();
    checks++;
    if (int_ack !== 1'b1) begin errors++; $display("FAIL rst_jump_reach got ack=%b want 1", int_ack); end
    reset = 1'b1;
    #1;
    checks++;
    if (int_ack !== 1'b0 || flush !== 1'b0)
      begin errors++; $display("FAIL rst_jump_gate got ack=%b flush=%b want 0 0", int_ack, flush); end
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (pc !== 32'h20 || int_ack !== 1'b0 || push_valid !== 1'b0 || push_pc !== 32'h0)
      begin errors++; $display("FAIL rst_jump_after got pc=%h ack=%b push=%b push_pc=%h want 20 0 0 0", pc, int_ack, push_valid, push_pc); end
    for (int i = 1; i <= 2; i++) begin
      tick();
      checks++;
      if (pc !== 32'h20 + 32'(i) || push_valid !== 1'b0 || int_ack !== 1'b0)
        begin errors++; $display("FAIL rst_jump_run_%0d got pc=%h push=%b ack=%b want %h 0 0", i, pc, push_valid, int_ack, 32'h20 + 32'(i)); end
    end
  endtask

  task automatic test_wrap();
    goto_pc(32'hFFFF_FFFF);
    checks++;
    if (pc_plus1 !== 32'h0) begin errors++; $display("FAIL wrap_plus1 got %h want 0", pc_plus1); end
    tick();
    checks++;
    if (pc !== 32'h0) begin errors++; $display("FAIL wrap_pc got %h want 0", pc); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_branch_vs_return();
    test_stall();
    test_ldm_pair();
    test_interrupt();
    test_reset_int_jump();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
